// File: rtl/prbs_rx_checker_if.sv
// RX user-interface word stream from one GTX lane into the PRBS-7 checker.
interface prbs_rx_checker_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;

    modport master (output rx_data, output rx_valid);
    modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/prbs_rx_checker.sv
// Receive-side PRBS-7 (x^7+x^6+1) checker for one GTX lane.
// Stage 1 registers the RX word; stage 2 compares it against the word predicted
// from the previous valid word's low 7 bits, runs the HUNT/SYNC/LOCKED machine,
// keeps saturating bit/word error counts and drives the front-panel LED vector.
module prbs_rx_checker #(
    parameter int DATA_W       = 16,
    parameter int LOCK_WORDS   = 64,
    parameter int UNLOCK_WORDS = 16,
    parameter int CNT_W        = 32,
    parameter int STRETCH      = 4_000_000
) (
    input  logic              clk160,
    input  logic              _reset,
    prbs_rx_checker_if.slave  rx,
    input  logic              clr_cnt,
    output logic              locked,
    output logic [CNT_W-1:0]  bit_err_cnt,
    output logic [CNT_W-1:0]  word_err_cnt,
    output logic [0:7]        led_fp
);
    localparam int POP_W  = $clog2(DATA_W + 1);
    localparam int GOOD_W = $clog2(LOCK_WORDS + 1);
    localparam int BAD_W  = $clog2(UNLOCK_WORDS + 1);
    localparam int STR_W  = $clog2(STRETCH + 1);
    localparam int HB_W   = 27;

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_WORDS - 1);
    localparam logic [BAD_W-1:0]  BAD_ONE   = BAD_W'(1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_WORDS - 1);
    localparam logic [STR_W-1:0]  STR_ZERO  = {STR_W{1'b0}};
    localparam logic [STR_W-1:0]  STR_ONE   = STR_W'(1);
    localparam logic [STR_W-1:0]  STR_LOAD  = STR_W'(STRETCH);
    localparam logic [HB_W-1:0]   HB_ONE    = 27'd1;
    localparam logic [0:7]        LED_RST   = 8'b0001_0000;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Predict a whole word from a 7-bit seed; seed bit 6 is the oldest bit and
    // the first generated bit lands in the MSB (oldest position of the word).
    function automatic logic [DATA_W-1:0] prbs7_expect(input logic [6:0] seed);
        logic [6:0]        sr;
        logic              nb;
        logic [DATA_W-1:0] word;
        sr   = seed;
        word = {DATA_W{1'b0}};
        for (int i = DATA_W - 1; i >= 0; i--) begin
            nb      = sr[6] ^ sr[5];
            word[i] = nb;
            sr      = {sr[5:0], nb};
        end
        return word;
    endfunction

    function automatic logic [POP_W-1:0] popcount(input logic [DATA_W-1:0] v);
        logic [POP_W-1:0] n;
        n = {POP_W{1'b0}};
        for (int i = 0; i < DATA_W; i++) begin
            n = n + {{(POP_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    // Add with clamp to all-ones; an add that would carry out saturates.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [POP_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W+1-POP_W){1'b0}}, b};
        return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
    endfunction

    logic [DATA_W-1:0] data_r;
    logic              valid_r;
    logic [6:0]        seed_r;
    state_t            state_r;
    logic [GOOD_W-1:0] good_cnt_r;
    logic [BAD_W-1:0]  bad_cnt_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [CNT_W-1:0]  word_cnt_r;
    logic              sticky_r;
    logic [STR_W-1:0]  stretch_r;
    logic [HB_W-1:0]   hb_r;
    logic              locked_r;
    logic [0:7]        led_fp_r;

    logic [DATA_W-1:0] exp_word_s;
    logic [DATA_W-1:0] err_bits_s;
    logic [POP_W-1:0]  err_pop_s;
    logic              zero_seed_s;
    logic              word_err_s;
    logic              count_err_s;
    logic [6:0]        seed_nxt_s;
    state_t            state_nxt_s;
    logic [GOOD_W-1:0] good_nxt_s;
    logic [BAD_W-1:0]  bad_nxt_s;
    logic [CNT_W-1:0]  bit_nxt_s;
    logic [CNT_W-1:0]  word_nxt_s;
    logic              sticky_nxt_s;
    logic [STR_W-1:0]  stretch_nxt_s;
    logic [HB_W-1:0]   hb_nxt_s;
    logic              locked_nxt_s;
    logic [0:7]        led_nxt_s;

    // Stage 1: capture the raw RX word and its qualifier every cycle.
    always_ff @(posedge clk160 or negedge _reset) begin
        if (!_reset) begin
            data_r  <= {DATA_W{1'b0}};
            valid_r <= 1'b0;
        end else begin
            data_r  <= rx.rx_data;
            valid_r <= rx.rx_valid;
        end
    end

    // Compare the registered word with the prediction and pick the next seed.
    always_comb begin
        exp_word_s  = prbs7_expect(seed_r);
        err_bits_s  = data_r ^ exp_word_s;
        err_pop_s   = popcount(err_bits_s);
        zero_seed_s = (data_r[6:0] == 7'd0);
        word_err_s  = (err_pop_s != {POP_W{1'b0}}) || zero_seed_s;
        count_err_s = valid_r && (state_r == ST_LOCKED) && word_err_s;
        if (valid_r && !zero_seed_s) begin
            seed_nxt_s = data_r[6:0];
        end else begin
            seed_nxt_s = seed_r;
        end
    end

    // Lock state register with its run-length counters.
    always_ff @(posedge clk160 or negedge _reset) begin
        if (!_reset) begin
            state_r    <= ST_HUNT;
            good_cnt_r <= {GOOD_W{1'b0}};
            bad_cnt_r  <= {BAD_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            good_cnt_r <= good_nxt_s;
            bad_cnt_r  <= bad_nxt_s;
        end
    end

    // Next lock state; only valid words move the machine or its run counters.
    always_comb begin
        state_nxt_s = state_r;
        good_nxt_s  = good_cnt_r;
        bad_nxt_s   = bad_cnt_r;
        if (valid_r) begin
            case (state_r)
                ST_HUNT: begin
                    if (!zero_seed_s) begin
                        state_nxt_s = ST_SYNC;
                        good_nxt_s  = {GOOD_W{1'b0}};
                        bad_nxt_s   = {BAD_W{1'b0}};
                    end else begin
                        state_nxt_s = ST_HUNT;
                    end
                end
                ST_SYNC: begin
                    if (word_err_s) begin
                        state_nxt_s = ST_HUNT;
                    end else if (good_cnt_r == GOOD_LAST) begin
                        state_nxt_s = ST_LOCKED;
                        good_nxt_s  = good_cnt_r + GOOD_ONE;
                        bad_nxt_s   = {BAD_W{1'b0}};
                    end else begin
                        good_nxt_s  = good_cnt_r + GOOD_ONE;
                    end
                end
                ST_LOCKED: begin
                    if (!word_err_s) begin
                        bad_nxt_s = {BAD_W{1'b0}};
                    end else if (bad_cnt_r == BAD_LAST) begin
                        state_nxt_s = ST_HUNT;
                        bad_nxt_s   = {BAD_W{1'b0}};
                    end else begin
                        bad_nxt_s   = bad_cnt_r + BAD_ONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_HUNT;
                    good_nxt_s  = {GOOD_W{1'b0}};
                    bad_nxt_s   = {BAD_W{1'b0}};
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Next values of counters, sticky flag, activity stretch and LED vector.
    always_comb begin
        bit_nxt_s     = bit_cnt_r;
        word_nxt_s    = word_cnt_r;
        sticky_nxt_s  = sticky_r;
        stretch_nxt_s = stretch_r;
        if (clr_cnt) begin
            bit_nxt_s    = CNT_ZERO;
            word_nxt_s   = CNT_ZERO;
            sticky_nxt_s = 1'b0;
        end else if (count_err_s) begin
            bit_nxt_s    = sat_add(bit_cnt_r, err_pop_s);
            word_nxt_s   = sat_add(word_cnt_r, {{(POP_W-1){1'b0}}, 1'b1});
            sticky_nxt_s = 1'b1;
        end else begin
            sticky_nxt_s = sticky_r;
        end
        if (count_err_s) begin
            stretch_nxt_s = STR_LOAD;
        end else if (stretch_r != STR_ZERO) begin
            stretch_nxt_s = stretch_r - STR_ONE;
        end else begin
            stretch_nxt_s = STR_ZERO;
        end
        hb_nxt_s     = hb_r + HB_ONE;
        locked_nxt_s = (state_nxt_s == ST_LOCKED);
        led_nxt_s[0] = locked_nxt_s;
        led_nxt_s[1] = sticky_nxt_s;
        led_nxt_s[2] = (stretch_nxt_s != STR_ZERO);
        led_nxt_s[3] = (state_nxt_s == ST_HUNT);
        led_nxt_s[4] = hb_nxt_s[26];
        led_nxt_s[5] = (word_nxt_s == CNT_MAX);
        led_nxt_s[6] = (state_nxt_s == ST_SYNC);
        led_nxt_s[7] = valid_r;
    end

    // Stage 2 datapath and output registers.
    always_ff @(posedge clk160 or negedge _reset) begin
        if (!_reset) begin
            seed_r     <= 7'd0;
            bit_cnt_r  <= CNT_ZERO;
            word_cnt_r <= CNT_ZERO;
            sticky_r   <= 1'b0;
            stretch_r  <= STR_ZERO;
            hb_r       <= {HB_W{1'b0}};
            locked_r   <= 1'b0;
            led_fp_r   <= LED_RST;
        end else begin
            seed_r     <= seed_nxt_s;
            bit_cnt_r  <= bit_nxt_s;
            word_cnt_r <= word_nxt_s;
            sticky_r   <= sticky_nxt_s;
            stretch_r  <= stretch_nxt_s;
            hb_r       <= hb_nxt_s;
            locked_r   <= locked_nxt_s;
            led_fp_r   <= led_nxt_s;
        end
    end

    assign locked       = locked_r;
    assign bit_err_cnt  = bit_cnt_r;
    assign word_err_cnt = word_cnt_r;
    assign led_fp       = led_fp_r;

endmodule

// File: tb/tb_prbs_rx_checker.sv
// Scoreboard bench for prbs_rx_checker: two instances (32-bit and 8-bit counters)
// share one stimulus stream; a bit-level reference model predicts every cycle.
module tb_prbs_rx_checker;
    localparam int DATA_W       = 16;
    localparam int LOCK_WORDS   = 64;
    localparam int UNLOCK_WORDS = 16;
    localparam int STRETCH_A    = 4_000_000;
    localparam int STRETCH_B    = 20;
    localparam logic [63:0] CAP_A = 64'hFFFF_FFFF;
    localparam logic [63:0] CAP_B = 64'hFF;
    localparam int M_HUNT = 0, M_SYNC = 1, M_LOCKED = 2;

    logic clk160  = 1'b0;
    logic _reset  = 1'b0;
    logic clr_cnt = 1'b0;
    prbs_rx_checker_if #(.DATA_W(DATA_W)) rx_if();

    logic        locked_a, locked_b;
    logic [31:0] bit_a, word_a;
    logic [7:0]  bit_b, word_b;
    logic [0:7]  led_a, led_b;

    prbs_rx_checker #(.DATA_W(DATA_W), .LOCK_WORDS(LOCK_WORDS), .UNLOCK_WORDS(UNLOCK_WORDS),
                      .CNT_W(32), .STRETCH(STRETCH_A)) dut_a (
        .clk160(clk160), ._reset(_reset), .rx(rx_if), .clr_cnt(clr_cnt),
        .locked(locked_a), .bit_err_cnt(bit_a), .word_err_cnt(word_a), .led_fp(led_a));

    prbs_rx_checker #(.DATA_W(DATA_W), .LOCK_WORDS(LOCK_WORDS), .UNLOCK_WORDS(UNLOCK_WORDS),
                      .CNT_W(8), .STRETCH(STRETCH_B)) dut_b (
        .clk160(clk160), ._reset(_reset), .rx(rx_if), .clr_cnt(clr_cnt),
        .locked(locked_b), .bit_err_cnt(bit_b), .word_err_cnt(word_b), .led_fp(led_b));

    always #5 clk160 = ~clk160;

    longint cyc = 0;
    always @(posedge clk160) cyc <= cyc + 1;

    typedef struct {
        longint      due;
        logic        locked_a;
        logic [31:0] bit_a, word_a;
        logic [0:7]  led_a;
        logic        locked_b;
        logic [7:0]  bit_b, word_b;
        logic [0:7]  led_b;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_state, m_good, m_bad;
    logic [6:0]  m_seed;
    logic [63:0] m_bit_a, m_word_a, m_bit_b, m_word_b, m_hb;
    longint      m_str_a, m_str_b;
    logic        m_sticky, m_v1;
    logic [DATA_W-1:0] m_d1;
    bit          gh[$];  // last 7 bits of the clean transmit stream, oldest first

    function automatic logic [DATA_W-1:0] model_expect(input logic [6:0] seed);
        bit q[$];
        logic [DATA_W-1:0] w;
        for (int i = 6; i >= 0; i--) q.push_back(seed[i]);
        for (int i = 0; i < DATA_W; i++) q.push_back(q[i] ^ q[i+1]);
        for (int i = 0; i < DATA_W; i++) w[DATA_W-1-i] = q[7+i];
        return w;
    endfunction

    function automatic logic [63:0] sat(input logic [63:0] v, input logic [63:0] cap);
        return (v > cap) ? cap : v;
    endfunction

    task automatic model_reset();
        m_state = M_HUNT; m_good = 0; m_bad = 0; m_seed = 7'd0;
        m_bit_a = 0; m_word_a = 0; m_bit_b = 0; m_word_b = 0; m_hb = 0;
        m_str_a = 0; m_str_b = 0; m_sticky = 1'b0; m_v1 = 1'b0; m_d1 = '0;
        sb_q.delete();
    endtask

    task automatic next_clean(output logic [DATA_W-1:0] w);
        bit nb;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            nb = gh[0] ^ gh[1];
            w[i] = nb;
            gh.push_back(nb);
            void'(gh.pop_front());
        end
    endtask

    // One clock edge of the checker: process the word held in stage 1, apply clr.
    task automatic model_step(input logic [DATA_W-1:0] d, input logic v, input logic c);
        exp_t e;
        logic [DATA_W-1:0] ew;
        int pop;
        bit zero, err, counted;
        pop = 0; counted = 0;
        if (m_v1) begin
            ew = model_expect(m_seed);
            for (int i = 0; i < DATA_W; i++) if (ew[i] != m_d1[i]) pop++;
            zero = (m_d1[6:0] == 7'd0);
            err  = (pop != 0) || zero;
            counted = (m_state == M_LOCKED) && err;
            if (m_state == M_HUNT) begin
                if (!zero) begin m_state = M_SYNC; m_good = 0; end
            end else if (m_state == M_SYNC) begin
                if (err) m_state = M_HUNT;
                else begin
                    m_good++;
                    if (m_good == LOCK_WORDS) begin m_state = M_LOCKED; m_bad = 0; end
                end
            end else begin
                if (err) begin
                    m_bad++;
                    if (m_bad == UNLOCK_WORDS) begin m_state = M_HUNT; m_bad = 0; end
                end else m_bad = 0;
            end
            if (!zero) m_seed = m_d1[6:0];
        end
        if (c) begin
            m_bit_a = 0; m_word_a = 0; m_bit_b = 0; m_word_b = 0; m_sticky = 1'b0;
        end else if (counted) begin
            m_bit_a  = sat(m_bit_a + pop, CAP_A);  m_word_a = sat(m_word_a + 1, CAP_A);
            m_bit_b  = sat(m_bit_b + pop, CAP_B);  m_word_b = sat(m_word_b + 1, CAP_B);
            m_sticky = 1'b1;
        end
        if (counted) begin m_str_a = STRETCH_A; m_str_b = STRETCH_B; end
        else begin
            if (m_str_a > 0) m_str_a--;
            if (m_str_b > 0) m_str_b--;
        end
        m_hb++;
        e.due = cyc + 1;
        e.locked_a = (m_state == M_LOCKED);
        e.bit_a = m_bit_a[31:0]; e.word_a = m_word_a[31:0];
        e.locked_b = (m_state == M_LOCKED);
        e.bit_b = m_bit_b[7:0]; e.word_b = m_word_b[7:0];
        e.led_a[0] = e.locked_a;           e.led_b[0] = e.locked_b;
        e.led_a[1] = m_sticky;             e.led_b[1] = m_sticky;
        e.led_a[2] = (m_str_a != 0);       e.led_b[2] = (m_str_b != 0);
        e.led_a[3] = (m_state == M_HUNT);  e.led_b[3] = (m_state == M_HUNT);
        e.led_a[4] = m_hb[26];             e.led_b[4] = m_hb[26];
        e.led_a[5] = (m_word_a == CAP_A);  e.led_b[5] = (m_word_b == CAP_B);
        e.led_a[6] = (m_state == M_SYNC);  e.led_b[6] = (m_state == M_SYNC);
        e.led_a[7] = m_v1;                 e.led_b[7] = m_v1;
        sb_q.push_back(e);
        m_d1 = d; m_v1 = v;
    endtask

    task automatic drive(input logic [DATA_W-1:0] d, input logic v, input logic c);
        rx_if.rx_data  = d;
        rx_if.rx_valid = v;
        clr_cnt        = c;
        model_step(d, v, c);
    endtask

    // Monitor: compare DUT outputs with every prediction that has come due.
    always @(negedge clk160) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_e = sb_q.pop_front();
            if (mon_e.due != cyc) begin
                chk("sb_due", mon_e.due, cyc);
            end else begin
                chk("locked_a", locked_a, mon_e.locked_a);
                chk("bit_a",    bit_a,    mon_e.bit_a);
                chk("word_a",   word_a,   mon_e.word_a);
                chk("led_a",    led_a,    mon_e.led_a);
                chk("locked_b", locked_b, mon_e.locked_b);
                chk("bit_b",    bit_b,    mon_e.bit_b);
                chk("word_b",   word_b,   mon_e.word_b);
                chk("led_b",    led_b,    mon_e.led_b);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_locked_a"}, locked_a, 64'd0);
        chk({tag, "_bit_a"},    bit_a,    64'd0);
        chk({tag, "_word_a"},   word_a,   64'd0);
        chk({tag, "_led_a"},    led_a,    64'h10);
        chk({tag, "_locked_b"}, locked_b, 64'd0);
        chk({tag, "_bit_b"},    bit_b,    64'd0);
        chk({tag, "_led_b"},    led_b,    64'h10);
    endtask

    // Clean stream from HUNT with an empty pipeline: seed word plus LOCK_WORDS good words.
    task automatic lock_run(input string tag, input int n);
        logic [DATA_W-1:0] w;
        for (int k = 0; k < n; k++) begin
            @(negedge clk160);
            if (k == LOCK_WORDS + 1) chk({tag, "_not_yet"}, locked_a, 64'd0);
            if (k == LOCK_WORDS + 2) chk({tag, "_locked"},  locked_a, 64'd1);
            next_clean(w);
            drive(w, 1'b1, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk160);
            drive(DATA_W'($urandom), 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [DATA_W-1:0] w;
        rx_if.rx_data  = '0;
        rx_if.rx_valid = 1'b0;
        for (int i = 0; i < 7; i++) gh.push_back(1'b1);
        model_reset();
        repeat (3) @(negedge clk160);
        check_reset_outputs("por");
        @(negedge clk160);
        _reset = 1'b1;
        drive('0, 1'b0, 1'b0);

        // Clean stream lock
        lock_run("lock_clean", 80);

        // Single bit flip while locked
        @(negedge clk160);
        next_clean(w);
        w[3] = ~w[3];
        drive(w, 1'b1, 1'b0);
        lock_run("after_flip", 6);
        idle(2);
        chk("flip_lock_held", locked_a, 64'd1);

        // Twenty zero words drop lock on the sixteenth
        for (int k = 0; k < 20; k++) begin
            @(negedge clk160);
            drive('0, 1'b1, 1'b0);
        end
        idle(2);
        chk("zero_unlocked", locked_a, 64'd0);
        chk("zero_hunt", led_a[3], 64'd1);
        lock_run("relock_zero", 80);

        // Saturate the 8-bit counters, then clear in the same cycle as an error
        for (int it = 0; it < 130; it++) begin
            @(negedge clk160);
            next_clean(w);
            w[$urandom_range(0, DATA_W-1)] ^= 1'b1;
            drive(w, 1'b1, 1'b0);
            lock_run("sat", 3);
        end
        @(negedge clk160);
        next_clean(w);
        w[12] = ~w[12];
        drive(w, 1'b1, 1'b0);
        @(negedge clk160);
        next_clean(w);
        drive(w, 1'b1, 1'b1);
        lock_run("after_clr", 4);

        // Asynchronous reset while locked
        @(negedge clk160);
        #2 _reset = 1'b0;
        #1 check_reset_outputs("async");
        model_reset();
        repeat (2) @(negedge clk160);
        _reset = 1'b1;
        drive('0, 1'b0, 1'b0);
        lock_run("relock_reset", 80);

        // Valid gaps: 5 on / 5 off from HUNT
        for (int k = 0; k < 20; k++) begin
            @(negedge clk160);
            drive('0, 1'b1, 1'b0);
        end
        idle(2);
        for (int g = 0; g < 40; g++) begin
            lock_run("gap", 5);
            idle(5);
        end
        chk("gap_locked", locked_a, 64'd1);

        // Randomised traffic: gaps, bit errors, zero words, clears
        for (int k = 0; k < 900; k++) begin
            @(negedge clk160);
            if ($urandom_range(0, 99) < 75) begin
                next_clean(w);
                if ($urandom_range(0, 99) < 6) w[$urandom_range(0, DATA_W-1)] ^= 1'b1;
                if ($urandom_range(0, 99) < 2) w = '0;
                drive(w, 1'b1, ($urandom_range(0, 99) < 2));
            end else begin
                drive(DATA_W'($urandom), 1'b0, ($urandom_range(0, 99) < 2));
            end
        end
        idle(3);
        repeat (2) @(negedge clk160);
        chk("sb_drained", sb_q.size(), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/prbs_rx_checker.md
# prbs_rx_checker

Receive-side PRBS-7 checker for one GTX lane on the OTMB PRBS link test. Consumes the parallel word stream from the transceiver RX user interface and maintains lock state and saturating error counts. Drives the `led_fp[0:7]` status vector, which the top level routes to the front-panel LEDs and the VIO `SYNC_IN` bus. One instance per lane; lane 0 feeds `led_fp`.

## Interface
- `DATA_W`, 16: RX word width; even, 8..32.
- `LOCK_WORDS`, 64: consecutive error-free words needed to declare lock.
- `UNLOCK_WORDS`, 16: consecutive errored words that drop lock.
- `CNT_W`, 32: width of the bit- and word-error counters.
- `STRETCH`, 4_000_000: cycles the error-activity LED is held after an error.
- `clk160`  in  1: RX user clock; the only clock.
- `_reset`  in  1: asynchronous, active-low reset.
- `rx_data`  in  DATA_W: RX word; bit DATA_W-1 is the oldest bit in time.
- `rx_valid`  in  1: `rx_data` qualifier.
- `clr_cnt`  in  1: synchronous clear of counters and the sticky flag, level-sensitive.
- `locked`  out  1: lock status.
- `bit_err_cnt`  out  CNT_W: saturating count of mismatched bits while locked.
- `word_err_cnt`  out  CNT_W: saturating count of errored words while locked.
- `led_fp`  out  [0:7]: status LEDs, active-high.

## Operation
- **Stage 1 (input register):** registers `rx_data` and `rx_valid`. While `rx_valid` is low, no state changes.
- **Expected word:** computed combinationally from the low 7 bits of the previous valid word (self-synchronising). Serial recurrence is b[n] = b[n-7] ^ b[n-6] (x^7+x^6+1), applied MSB to LSB.
- **Error detection:** `err_bits` = received XOR expected; `err_pop` = popcount of `err_bits`; a word is errored if `err_pop` != 0.
- **Zero-seed rule:** a word whose low 7 bits are all zero is always errored and never used as a seed.
- **State machine, HUNT:**
  - On each valid word whose low 7 bits are non-zero, load the seed and go to SYNC with `good_cnt`=0.
  - If the low 7 bits are zero, stay in HUNT.
- **State machine, SYNC:**
  - A good word increments `good_cnt`.
  - When `good_cnt` reaches LOCK_WORDS, go to LOCKED.
  - An errored word returns to HUNT.
- **State machine, LOCKED:**
  - An errored word increments `bad_cnt`; a good word clears it.
  - When `bad_cnt` reaches UNLOCK_WORDS, go to HUNT.
- **Error counting:** only in LOCKED. This includes the word that causes the unlock transition.
  - `bit_err_cnt` += `err_pop`.
  - `word_err_cnt` += 1.
  - Both counters saturate at all-ones and never wrap. A partial add that would overflow clamps to all-ones.
- **Sticky error flag:** set by any counted error.
- **Stretch counter:** reloads to STRETCH on any counted error, then decrements to 0.
- **`clr_cnt`:**
  - Zeroes both counters and the sticky flag.
  - Has priority over a simultaneous increment in the same cycle.
  - Does not affect the state machine or the stretch counter.
- **`led_fp` mapping:**
  - [0] = `locked`.
  - [1] = sticky error flag.
  - [2] = stretch counter != 0.
  - [3] = state is HUNT.
  - [4] = heartbeat, bit 26 of a free-running counter.
  - [5] = `word_err_cnt` saturated.
  - [6] = state is SYNC.
  - [7] = registered `rx_valid`.

## Timing
- **Reset:** on assertion of `_reset`, immediately:
  - state HUNT, all counters 0, sticky flag 0, `locked`=0;
  - `led_fp`=8'b0001_0000 ([3]=1, all other bits 0).
- **Latency:** a word presented with `rx_valid`=1 at edge k is registered at k. The resulting state, counters and `led_fp` update on edge k+1.
- **Lock:** `locked` rises on the edge that registers the LOCK_WORDS-th consecutive good word after the seed (stage-2 edge).
- **Unlock:** `locked` falls on the edge that processes the UNLOCK_WORDS-th consecutive errored word.
- **Reset mid-operation:** reset is asynchronous. Release is sampled on the next `clk160` edge, and operation restarts from HUNT.
- **Gaps:** `rx_valid` gaps do not break the consecutive-word runs or the seed.

## Test plan
- **Clean stream:** reset, then a clean PRBS-7 stream from seed 7'h7F with `rx_valid` continuous -> `locked`=1 after exactly LOCK_WORDS+1 words (+1 cycle latency); both counters stay 0; `led_fp[0]`=1, `led_fp[3]`=0.
- **Single bit flip:** while locked, flip bit 3 of one word -> word N is errored via its own mismatch and word N+1 via the corrupted seed, so `bit_err_cnt` rises by the mismatches in both; `word_err_cnt`=2; sticky flag and `led_fp[2]` set; lock held.
- **Zero words:** feed 20 all-zero words while locked -> `locked` falls on the 16th word; `word_err_cnt`=16; state HUNT and stays in HUNT through the remaining zero words.
- **Saturation and clear:** preload near saturation with CNT_W=8 and inject errored words -> both counters clamp at 8'hFF and `led_fp[5]`=1; assert `clr_cnt` in the same cycle as an error -> counters read 0.
- **Reset mid-run:** assert `_reset` mid-stream while locked -> all outputs take their reset values immediately, with no clock; after release, relock takes the full LOCK_WORDS again.
- **Valid gaps:** drop `rx_valid` for 5 cycles in every 10 on a clean stream -> lock still achieved; counters stay 0; no state change on invalid cycles.
